// File: rtl/rf_pkg.sv
// Shared register-file definitions: FSM states, default sizing and address qualification.
// Decode and writeback import the same defaults so all three agree on the file geometry.
package rf_pkg;

  localparam int RF_XLEN  = 32;
  localparam int RF_NREGS = 32;
  localparam int RF_NREAD = 2;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rf_state_e;

  // x0 is hardwired zero, so any access to address 0 is not a live register.
  function automatic logic rf_live(input int unsigned addr);
    return (addr != 32'd0);
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback-facing bus of the multi-port register file.
interface reg_file_mp_if
  import rf_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int NREGS = RF_NREGS,
  parameter int NREAD = RF_NREAD
) ();

  localparam int AW = $clog2(NREGS);

  logic                           wen;
  logic [AW-1:0]                  addr_w;
  logic [XLEN-1:0]                din;
  logic [NREAD-1:0][AW-1:0]       rd_addr;
  logic [NREAD-1:0][XLEN-1:0]     rd_data;
  logic [NREAD-1:0]               rd_pend;
  logic                           set_en;
  logic [AW-1:0]                  set_addr;
  logic                           ready;

  modport master (
    output wen, addr_w, din, rd_addr, set_en, set_addr,
    input  rd_data, rd_pend, ready
  );

  modport slave (
    input  wen, addr_w, din, rd_addr, set_en, set_addr,
    output rd_data, rd_pend, ready
  );

endinterface

// File: rtl/rf_read_port.sv
// One read port: zero register, same-cycle writeback bypass, then stored value and pending bit.
module rf_read_port
  import rf_pkg::*;
#(
  parameter int XLEN = RF_XLEN,
  parameter int AW   = $clog2(RF_NREGS)
) (
  input  logic            run,
  input  logic [AW-1:0]   rd_addr,
  input  logic            wen,
  input  logic [AW-1:0]   addr_w,
  input  logic [XLEN-1:0] din,
  input  logic [XLEN-1:0] reg_val,
  input  logic            pend_val,
  output logic [XLEN-1:0] rd_data,
  output logic            rd_pend
);

  // The bypassed write retires its producer, so a bypassed read is never pending.
  always_comb begin
    rd_data = '0;
    rd_pend = 1'b0;
    if (!run || !rf_live(32'(rd_addr))) begin
      rd_data = '0;
      rd_pend = 1'b0;
    end else if (wen && (addr_w == rd_addr)) begin
      rd_data = din;
      rd_pend = 1'b0;
    end else begin
      rd_data = reg_val;
      rd_pend = pend_val;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port integer register file with bypass and pending scoreboard.
// Storage has no reset; a post-reset sequencer walks x1..x(NREGS-1) writing zero.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int XLEN  = RF_XLEN,
  parameter int NREGS = RF_NREGS,
  parameter int NREAD = RF_NREAD
) (
  input logic          clk,
  input logic          rst,
  reg_file_mp_if.slave bus
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] FIRST_IDX = AW'(1);
  localparam logic [AW-1:0] LAST_IDX  = AW'(NREGS - 1);

  rf_state_e                  state_r;
  rf_state_e                  state_s;
  logic [AW-1:0]              idx_r;
  logic                       ready_r;
  logic [XLEN-1:0]            regs_r [NREGS];
  logic [NREGS-1:0]           pend_r;
  logic                       run_s;
  logic                       clr_we_s;
  logic                       run_we_s;
  logic                       run_set_s;
  logic [NREAD-1:0][XLEN-1:0] rd_data_s;
  logic [NREAD-1:0]           rd_pend_s;

  assign run_s     = (state_r == ST_RUN);
  assign clr_we_s  = !rst && !run_s;
  assign run_we_s  = !rst && run_s && bus.wen && rf_live(32'(bus.addr_w));
  assign run_set_s = !rst && run_s && bus.set_en && rf_live(32'(bus.set_addr));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_CLEAR;
    else     state_r <= state_s;
  end

  // FSM next state: leave CLEAR once the last register is being zeroed
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (idx_r == LAST_IDX) state_s = ST_RUN;
        else                   state_s = ST_CLEAR;
      end
      ST_RUN:  state_s = ST_RUN;
      default: state_s = ST_CLEAR;
    endcase
  end

  // Clear index; parks at the last entry instead of wrapping
  always_ff @(posedge clk) begin
    if (rst)                                          idx_r <= FIRST_IDX;
    else if ((state_r == ST_CLEAR) && (idx_r != LAST_IDX)) idx_r <= idx_r + AW'(1);
    else                                              idx_r <= idx_r;
  end

  // Ready flag, rises on the edge that enters RUN
  always_ff @(posedge clk) begin
    if (rst) ready_r <= 1'b0;
    else     ready_r <= (state_s == ST_RUN);
  end

  // Storage array: zeroed by the sequencer, written by writeback in RUN
  always_ff @(posedge clk) begin
    if (clr_we_s)      regs_r[idx_r]      <= '0;
    else if (run_we_s) regs_r[bus.addr_w] <= bus.din;
  end

  // Pending scoreboard; issue is applied after writeback so a same-address set wins
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r <= '0;
    end else begin
      if (run_we_s)  pend_r[bus.addr_w]   <= 1'b0;
      if (run_set_s) pend_r[bus.set_addr] <= 1'b1;
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    rf_read_port #(.XLEN(XLEN), .AW(AW)) u_port (
      .run      (run_s),
      .rd_addr  (bus.rd_addr[p]),
      .wen      (bus.wen),
      .addr_w   (bus.addr_w),
      .din      (bus.din),
      .reg_val  (regs_r[bus.rd_addr[p]]),
      .pend_val (pend_r[bus.rd_addr[p]]),
      .rd_data  (rd_data_s[p]),
      .rd_pend  (rd_pend_s[p])
    );
  end

  assign bus.rd_data = rd_data_s;
  assign bus.rd_pend = rd_pend_s;
  assign bus.ready   = ready_r;

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed vector table, reset/clear sequences, random vs model.
module tb_reg_file_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NREAD = 3;
  localparam int AW    = $clog2(NREGS);

  typedef struct packed {
    logic                       wen;
    logic [AW-1:0]              aw;
    logic [XLEN-1:0]            din;
    logic                       se;
    logic [AW-1:0]              sa;
    logic [NREAD-1:0][AW-1:0]   ra;
    logic [NREAD-1:0][XLEN-1:0] ed;
    logic [NREAD-1:0]           ep;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // behavioural reference state
  logic [XLEN-1:0]  m_regs [NREGS];
  logic [NREGS-1:0] m_pend;
  int               clr_cnt;
  logic             m_ready;

  reg_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) bus ();

  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkv(input logic wen, input int aw, input logic [31:0] din,
                               input logic se, input int sa,
                               input int r0, input int r1, input int r2,
                               input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                               input logic [2:0] ep);
    vec_t v;
    v.wen = wen; v.aw = AW'(aw); v.din = din; v.se = se; v.sa = AW'(sa);
    v.ra[0] = AW'(r0); v.ra[1] = AW'(r1); v.ra[2] = AW'(r2);
    v.ed[0] = d0; v.ed[1] = d1; v.ed[2] = d2;
    v.ep = ep;
    return v;
  endfunction

  task automatic expect_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic drive(input logic wen, input logic [AW-1:0] aw, input logic [XLEN-1:0] din,
                       input logic se, input logic [AW-1:0] sa);
    bus.wen = wen; bus.addr_w = aw; bus.din = din; bus.set_en = se; bus.set_addr = sa;
  endtask

  // expected read result straight from the read rules
  task automatic check_model(input string tag);
    logic [XLEN-1:0] ed;
    logic            ep;
    for (int p = 0; p < NREAD; p++) begin
      if (clr_cnt != NREGS - 1 || bus.rd_addr[p] == '0) begin
        ed = '0; ep = 1'b0;
      end else if (bus.wen && bus.addr_w == bus.rd_addr[p]) begin
        ed = bus.din; ep = 1'b0;
      end else begin
        ed = m_regs[bus.rd_addr[p]]; ep = m_pend[bus.rd_addr[p]];
      end
      checks++;
      if (bus.rd_data[p] !== ed || bus.rd_pend[p] !== ep) begin
        errors++;
        $display("FAIL %s port%0d addr=%0d got data=%h pend=%b expected data=%h pend=%b",
                 tag, p, bus.rd_addr[p], bus.rd_data[p], bus.rd_pend[p], ed, ep);
      end
    end
    expect_eq({tag, "_ready"}, 32'(bus.ready), 32'(m_ready));
  endtask

  // advance one clock and apply the edge to the model
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      clr_cnt = 0;
      m_pend  = '0;
      for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    end else if (clr_cnt < NREGS - 1) begin
      clr_cnt++;
    end else begin
      if (bus.wen && bus.addr_w != '0) begin
        m_regs[bus.addr_w] = bus.din;
        m_pend[bus.addr_w] = 1'b0;
      end
      if (bus.set_en && bus.set_addr != '0) m_pend[bus.set_addr] = 1'b1;
    end
    m_ready = !rst && (clr_cnt == NREGS - 1);
    #1;
  endtask

  // run the clear sequence with busy inputs, returning the number of edges until ready
  task automatic run_clear(input bit hit_x3, output int n);
    n = 0;
    while (bus.ready !== 1'b1 && n < 100) begin
      if (hit_x3) drive(1'b1, AW'(3), 32'hFFFF_FFFF, 1'b1, AW'(3));
      else        drive(1'($urandom), AW'($urandom), $urandom, 1'($urandom), AW'($urandom));
      for (int p = 0; p < NREAD; p++) bus.rd_addr[p] = hit_x3 ? AW'(3) : AW'($urandom);
      #2 check_model("clear");
      tick();
      n++;
    end
    drive(1'b0, '0, '0, 1'b0, '0);
  endtask

  vec_t tbl [12];
  int   n;

  initial begin
    drive(1'b0, '0, '0, 1'b0, '0);
    bus.rd_addr = '0;
    clr_cnt = 0; m_pend = '0; m_ready = 1'b0;
    for (int i = 0; i < NREGS; i++) m_regs[i] = '0;

    tbl[0]  = mkv(1, 5, 32'hDEAD_BEEF, 0, 0, 5, 0, 5, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 3'b000);
    tbl[1]  = mkv(0, 0, 0, 0, 0, 5, 5, 5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b000);
    tbl[2]  = mkv(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
    tbl[3]  = mkv(0, 0, 0, 0, 0, 5, 1, 31, 32'hDEAD_BEEF, 0, 0, 3'b000);
    tbl[4]  = mkv(0, 0, 0, 1, 7, 7, 7, 0, 0, 0, 0, 3'b000);
    tbl[5]  = mkv(0, 0, 0, 0, 0, 7, 6, 7, 0, 0, 0, 3'b101);
    tbl[6]  = mkv(1, 7, 32'h1234, 0, 0, 7, 7, 5, 32'h1234, 32'h1234, 32'hDEAD_BEEF, 3'b000);
    tbl[7]  = mkv(0, 0, 0, 0, 0, 7, 0, 7, 32'h1234, 0, 32'h1234, 3'b000);
    tbl[8]  = mkv(1, 9, 32'h55, 1, 9, 9, 9, 8, 32'h55, 32'h55, 0, 3'b000);
    tbl[9]  = mkv(0, 0, 0, 0, 0, 9, 8, 9, 32'h55, 0, 32'h55, 3'b101);
    tbl[10] = mkv(1, 9, 32'h66, 0, 0, 9, 9, 8, 32'h66, 32'h66, 0, 3'b000);
    tbl[11] = mkv(0, 0, 0, 0, 0, 9, 7, 5, 32'h66, 32'h1234, 32'hDEAD_BEEF, 3'b000);

    // power-on reset and first clear sequence
    tick(); tick();
    expect_eq("reset_ready", 32'(bus.ready), 32'd0);
    rst = 1'b0;
    run_clear(1'b0, n);
    expect_eq("clear_latency", 32'(n), 32'd31);
    for (int a = 1; a < NREGS; a++) begin
      bus.rd_addr[0] = AW'(a);
      #1 expect_eq("cleared_reg", bus.rd_data[0], 32'h0);
    end

    // directed vectors, each applied for one cycle
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].wen, tbl[i].aw, tbl[i].din, tbl[i].se, tbl[i].sa);
      bus.rd_addr = tbl[i].ra;
      #2;
      for (int p = 0; p < NREAD; p++) begin
        expect_eq($sformatf("vec%0d_data%0d", i, p), bus.rd_data[p], tbl[i].ed[p]);
        expect_eq($sformatf("vec%0d_pend%0d", i, p), 32'(bus.rd_pend[p]), 32'(tbl[i].ep[p]));
      end
      tick();
    end

    // mid-RUN reset: x3 written, x4 pending, then one reset cycle
    drive(1'b1, AW'(3), 32'hA5A5, 1'b1, AW'(4));
    tick();
    drive(1'b0, '0, '0, 1'b0, '0);
    bus.rd_addr[0] = AW'(3); bus.rd_addr[1] = AW'(4);
    #1 expect_eq("pre_rst_x3", bus.rd_data[0], 32'hA5A5);
    expect_eq("pre_rst_pend4", 32'(bus.rd_pend[1]), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_eq("rst_ready_drop", 32'(bus.ready), 32'd0);
    run_clear(1'b1, n);
    expect_eq("reclear_latency", 32'(n), 32'd31);
    bus.rd_addr[0] = AW'(3); bus.rd_addr[1] = AW'(4);
    #1 expect_eq("post_clear_x3", bus.rd_data[0], 32'h0);
    expect_eq("post_clear_pend4", 32'(bus.rd_pend[1]), 32'd0);

    // random traffic with occasional reset against the model
    for (int c = 0; c < 600; c++) begin
      drive(1'($urandom), AW'($urandom), $urandom, 1'($urandom_range(0, 3) == 0), AW'($urandom));
      for (int p = 0; p < NREAD; p++)
        bus.rd_addr[p] = ($urandom_range(0, 3) == 0) ? bus.addr_w : AW'($urandom);
      rst = ($urandom_range(0, 249) == 0);
      #2 check_model("random");
      tick();
      rst = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port integer register file for the RISC-V core, succeeding the single-write/dual-read file. It adds configurable width, depth and read-port count, same-cycle write-to-read bypass, and a per-register pending scoreboard for in-flight results. A post-reset clear sequencer zeroes the array so the storage needs no reset fan-out. The block sits between decode (read and issue) and writeback (write).

## Interface
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; power of two, ≥ 4; entry 0 is hardwired zero.
- NREAD, 2, number of read ports, 1..4.
- AW, $clog2(NREGS), derived address width; not to be overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- wen  in  1  writeback write enable.
- addr_w  in  AW  write address.
- din  in  XLEN  write data.
- rd_addr  in  NREAD×AW  read addresses, one per port.
- rd_data  out  NREAD×XLEN  read data, combinational.
- rd_pend  out  NREAD  register is awaiting writeback, combinational.
- set_en  in  1  issue marks a destination as pending.
- set_addr  in  AW  destination to mark.
- ready  out  1  high once the clear sequence has finished.

## Operation
- FSM states are CLEAR and RUN.
- rst has priority over everything. It forces CLEAR, sets idx to 1, clears all pending bits and drives ready to 0.
- CLEAR state:
  - Each cycle writes 0 to regs[idx] and increments idx.
  - When idx = NREGS-1 has been written, the FSM moves to RUN.
  - wen and set_en are ignored.
  - All rd_data read 0 and all rd_pend read 0.
- RUN state, writes:
  - When wen=1 and addr_w≠0, din is written to regs[addr_w] and pend[addr_w] is cleared.
  - A write to addr_w=0 is dropped.
- RUN state, issue:
  - When set_en=1 and set_addr≠0, pend[set_addr] is set.
  - If set_en and wen target the same address in the same cycle, the set wins: data is written and pend ends at 1, because a new producer is now outstanding.
- RUN state, reads (each port independently):
  - If rd_addr=0, rd_data=0 and rd_pend=0.
  - Else if wen=1 and addr_w=rd_addr, rd_data=din (bypass) and rd_pend=0.
  - Else rd_data=regs[rd_addr] and rd_pend=pend[rd_addr].
- A set_en is not visible on rd_pend until the cycle after.
- Any number of read ports may address the same register.

## Timing
- Reset values: ready=0, all rd_pend=0, all rd_data=0 while in CLEAR.
- Clear latency is NREGS-1 cycles after rst deasserts. ready rises on the edge that enters RUN; with NREGS=32 that is the 31st rising edge after rst low.
- Read latency is 0 cycles (combinational from rd_addr, wen, addr_w, din).
- Write latency is 1 edge to storage; bypass makes the value visible in the same cycle.
- rst asserted mid-RUN or mid-CLEAR restarts CLEAR from idx=1 on the next edge. Pending bits are lost and stored data becomes don't-care until it is re-cleared.
- idx is AW bits wide and never wraps, because CLEAR exits at NREGS-1.

## Structure
- The shared package rf_pkg holds:
  - the FSM state typedef (CLEAR/RUN);
  - a helper function that zero-qualifies a read, e.g. returning 0 for address 0;
  - default parameter constants shared with decode and writeback.
- One sub-module, rf_read_port, is natural: it performs the zero/bypass/pending selection for a single port and is instantiated NREAD times in a generate loop.
- The storage array and pending vector live in the top module.

## Test plan
- Release rst and poll ready. ready must rise exactly after 31 cycles (NREGS=32), and reading regs 1..31 must return 0x0000_0000.
- In RUN, write x5 with 0xDEAD_BEEF while rd_addr[0]=5 in the same cycle. rd_data[0]=0xDEAD_BEEF with no wait, and it still reads the same value the next cycle with wen=0.
- Drive wen=1, addr_w=0, din=0xFFFF_FFFF, then read x0 on all ports. The result is 0, rd_pend=0, and no other register changes.
- Drive set_en with set_addr=7. Next cycle rd_pend for x7 is 1. Write x7 with 0x1234. rd_pend is 0 in that same cycle and in later cycles.
- Drive set_en and wen both to x9 in the same cycle with din=0x55. Next cycle x9 reads 0x55 with rd_pend=1.
- Assert rst for 1 cycle mid-RUN after x3=0xA5A5 and pend[4]=1. ready drops, pend[4]=0, and after 31 cycles x3 reads 0. During CLEAR, wen to x3 has no effect.
